mine_placer: RTL and testbench

//  Parametrised mine-field generator for the MineSweeper datapath, successor to the fixed 8x8/8-mine generator.
//  On a start request it places exactly MINES distinct mines on a ROWS x COLS board and holds the result.

---
 rtl/minesweeper_pkg.sv | 47 ++++
 rtl/galois_lfsr.sv | 25 ++
 rtl/mine_placer.sv | 139 +++++++++++++
 tb/tb_mine_placer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/minesweeper_pkg.sv
// Shared MineSweeper types: FSM states, board-size helper, LFSR tap masks.
// Used by mine_placer and the datapath/gameboard blocks.
package minesweeper_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    PLACE,
    DONE
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Right-shift Galois masks giving maximal-length sequences
  function automatic logic [31:0] lfsr_mask(input int w);
    logic [31:0] m;
    unique case (w)
      4:       m = 32'h0000_000C;
      5:       m = 32'h0000_0014;
      6:       m = 32'h0000_0030;
      7:       m = 32'h0000_0060;
      8:       m = 32'h0000_00B8;
      9:       m = 32'h0000_0110;
      10:      m = 32'h0000_0240;
      11:      m = 32'h0000_0500;
      12:      m = 32'h0000_0E08;
      13:      m = 32'h0000_1C80;
      14:      m = 32'h0000_3802;
      15:      m = 32'h0000_6000;
      16:      m = 32'h0000_B400;
      17:      m = 32'h0001_2000;
      18:      m = 32'h0002_0400;
      19:      m = 32'h0007_2000;
      20:      m = 32'h0009_0000;
      24:      m = 32'h00E1_0000;
      32:      m = 32'hA300_0000;
      default: m = 32'h0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/galois_lfsr.sv
// Right-shift Galois LFSR with synchronous load.
// Advances every cycle unless ld is high.
module galois_lfsr #(
  parameter int W = 16,
  parameter logic [W-1:0] MASK = '0,
  parameter logic [W-1:0] SEED = '1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= SEED;
    end else if (ld) begin
      q <= ld_val;
    end else begin
      q <= (q >> 1) ^ (q[0] ? MASK : '0);
    end
  end

endmodule

// File: rtl/mine_placer.sv
// Places MINES distinct mines on a ROWS x COLS board from an LFSR stream.
// Define MINE_SAFE_ZONE_EN to keep the 3x3 around safe_idx mine-free.
module mine_placer
  import minesweeper_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int MINES  = 8,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1,
  localparam int CELLS = ROWS * COLS,
  localparam int IDX_W = clog2(CELLS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              seed_ld,
  input  logic [LFSR_W-1:0] seed_in,
`ifdef MINE_SAFE_ZONE_EN
  input  logic [IDX_W-1:0]  safe_idx,
`endif
  output logic              busy,
  output logic              done,
  output logic [CELLS-1:0]  mine_map,
  output logic [IDX_W:0]    mine_count
);

  localparam logic [LFSR_W-1:0] MASK = LFSR_W'(lfsr_mask(LFSR_W));
  localparam logic [IDX_W:0] LAST = (IDX_W + 1)'(MINES - 1);
  localparam int PAD_W = 2 ** IDX_W;

`ifdef MINE_SAFE_ZONE_EN
  localparam int MAX_MINES = CELLS - 9;
`else
  localparam int MAX_MINES = CELLS - 1;
`endif

  if (MINES < 1 || MINES > MAX_MINES) begin : g_bad_mines
    $error("mine_placer: MINES out of range");
  end

  if (LFSR_W < IDX_W || MASK == '0) begin : g_bad_lfsr
    $error("mine_placer: unsupported LFSR_W");
  end

  state_e              state;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [LFSR_W-1:0]   ld_val;
  logic                lfsr_ld;
  logic [IDX_W-1:0]    cand;
  logic [PAD_W-1:0]    map_pad;
  logic                excl;
  logic                cand_ok;
  logic                unused_lfsr;

  assign lfsr_ld = seed_ld && (state == IDLE);
  assign ld_val  = (seed_in == '0) ? SEED : seed_in;

  galois_lfsr #(
    .W    (LFSR_W),
    .MASK (MASK),
    .SEED (SEED)
  ) u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .ld     (lfsr_ld),
    .ld_val (ld_val),
    .q      (lfsr_q)
  );

  assign cand        = lfsr_q[IDX_W-1:0];
  assign unused_lfsr = ^lfsr_q;
  assign map_pad     = PAD_W'(mine_map);

`ifdef MINE_SAFE_ZONE_EN
  logic [IDX_W-1:0] safe_q;
  int cr, cc, sr, sc;

  // Row/col distance test, so the window never wraps across rows
  always_comb begin
    cr   = int'(cand) / COLS;
    cc   = int'(cand) % COLS;
    sr   = int'(safe_q) / COLS;
    sc   = int'(safe_q) % COLS;
    excl = (cr - sr <= 1) && (sr - cr <= 1) &&
           (cc - sc <= 1) && (sc - cc <= 1);
  end
`else
  assign excl = 1'b0;
`endif

  assign cand_ok = (int'(cand) < CELLS) && !map_pad[cand] && !excl;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      mine_map   <= '0;
      mine_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef MINE_SAFE_ZONE_EN
      safe_q     <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= CLEAR;
            busy  <= 1'b1;
`ifdef MINE_SAFE_ZONE_EN
            safe_q <= safe_idx;
`endif
          end
        end
        CLEAR: begin
          mine_map   <= '0;
          mine_count <= '0;
          state      <= PLACE;
        end
        PLACE: begin
          if (cand_ok) begin
            mine_map   <= mine_map | (CELLS'(1) << cand);
            mine_count <= mine_count + (IDX_W + 1)'(1);
            if (mine_count == LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mine_placer.sv
// Randomised bench for mine_placer against a cell-list placement model.
// Two instances: an 8x8 board and a small board.
module tb_mine_placer;

  localparam logic [15:0] SEEDV = 16'hACE1;
  localparam logic [15:0] POLY  = 16'hB400;
`ifdef MINE_SAFE_ZONE_EN
  localparam int SR = 4, SC = 4, SM = 7;
`else
  localparam int SR = 3, SC = 3, SM = 8;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic seed_ld = 1'b0;
  logic [15:0] seed_in = '0;
`ifdef MINE_SAFE_ZONE_EN
  logic [5:0] safe_a = '0;
  logic [3:0] safe_b = '0;
`endif
  logic busy_a, done_a, busy_b, done_b;
  logic [63:0] map_a;
  logic [6:0] cnt_a;
  logic [SR*SC-1:0] map_b;
  logic [4:0] cnt_b;

  int n_chk, n_err;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  mine_placer #(.ROWS(8), .COLS(8), .MINES(8)) dut_a (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start_a),
    .seed_ld    (seed_ld),
    .seed_in    (seed_in),
`ifdef MINE_SAFE_ZONE_EN
    .safe_idx   (safe_a),
`endif
    .busy       (busy_a),
    .done       (done_a),
    .mine_map   (map_a),
    .mine_count (cnt_a)
  );

  mine_placer #(.ROWS(SR), .COLS(SC), .MINES(SM)) dut_b (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start_b),
    .seed_ld    (seed_ld),
    .seed_in    (seed_in),
`ifdef MINE_SAFE_ZONE_EN
    .safe_idx   (safe_b),
`endif
    .busy       (busy_b),
    .done       (done_b),
    .mine_map   (map_b),
    .mine_count (cnt_b)
  );

  function automatic logic [15:0] step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
  endfunction

  // Reference LFSR value; the bench only pulses seed_ld while both DUTs idle
  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_lfsr <= SEEDV;
    else if (seed_ld) m_lfsr <= (seed_in == 16'h0) ? SEEDV : seed_in;
    else m_lfsr <= step(m_lfsr);
  end

  // Draw candidates one per cycle from l0 until the board holds `mines`
  function automatic void predict(input logic [15:0] l0, input int rows,
                                  input int cols, input int mines,
                                  input int safe, output logic [63:0] map,
                                  output int cyc);
    logic [15:0] x;
    int idxw, c, n;
    bit ok;
    x = l0;
    idxw = 0;
    while ((1 << idxw) < rows * cols) idxw++;
    map = '0;
    cyc = 0;
    n = 0;
    while (n < mines && cyc < 70000) begin
      c = int'(x) % (1 << idxw);
      ok = (c < rows * cols) && !map[c];
`ifdef MINE_SAFE_ZONE_EN
      if ((c / cols - safe / cols) >= -1 && (c / cols - safe / cols) <= 1 &&
          (c % cols - safe % cols) >= -1 && (c % cols - safe % cols) <= 1)
        ok = 1'b0;
`else
      if (safe > 1000) ok = 1'b0;
`endif
      if (ok) begin
        map[c] = 1'b1;
        n++;
      end
      cyc++;
      x = step(x);
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [15:0] v);
    @(negedge clk);
    seed_ld = 1'b1;
    seed_in = v;
    @(negedge clk);
    seed_ld = 1'b0;
  endtask

  task automatic run(input bit b, input bit ld, input logic [15:0] sv,
                     input int safe, input bit poke,
                     output logic [63:0] got);
    logic [63:0] exp;
    int ncyc, w, extra, rows, cols, mines;
    rows  = b ? SR : 8;
    cols  = b ? SC : 8;
    mines = b ? SM : 8;
    @(negedge clk);
    if (b) start_b = 1'b1;
    else start_a = 1'b1;
    if (ld) begin
      seed_ld = 1'b1;
      seed_in = sv;
    end
`ifdef MINE_SAFE_ZONE_EN
    if (b) safe_b = 4'(safe);
    else safe_a = 6'(safe);
`endif
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    seed_ld = 1'b0;
    chk("busy_clear", b ? busy_b : busy_a, 1);
    @(posedge clk);
    #1;
    predict(m_lfsr, rows, cols, mines, safe, exp, ncyc);
    w = 0;
    while (!(b ? done_b : done_a) && w < ncyc + 5) begin
      if (poke && w == 1) begin
        if (b) start_b = 1'b1;
        else start_a = 1'b1;
      end
      if (poke && w == 2) begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      @(posedge clk);
      #1;
      w++;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    chk("latency", w, ncyc);
    got = b ? 64'(map_b) : map_a;
    chk("map", got, exp);
    chk("count", b ? 64'(cnt_b) : 64'(cnt_a), mines);
    chk("popcount", $countones(got), mines);
    chk("busy_at_done", b ? busy_b : busy_a, 0);
    extra = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      extra += b ? (int'(done_b) + int'(busy_b)) : (int'(done_a) + int'(busy_a));
    end
    chk("single_done", extra, 0);
  endtask

  initial begin
    logic [63:0] m1, m2;
    int safe, dn, hit16;
    n_chk = 0;
    n_err = 0;
    hit16 = 0;
    repeat (2) @(negedge clk);
    chk("rst_map", map_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_lfsr", dut_a.lfsr_q, SEEDV);
    chk("rst_map_b", 64'(map_b), 0);
    resetn = 1'b1;

    load(16'h0001);
    repeat (3) @(negedge clk);
    run(0, 0, 0, 0, 0, m1);
    load(16'h0001);
    repeat (3) @(negedge clk);
    run(0, 0, 0, 0, 0, m2);
    chk("rerun_same", m2, m1);

    load(16'h0000);
    repeat (2) @(negedge clk);
    run(0, 0, 0, 27, 0, m1);
    load(SEEDV);
    repeat (2) @(negedge clk);
    run(0, 0, 0, 27, 0, m2);
    chk("zero_seed", m1, m2);

    run(0, 1, 16'h1234, 36, 0, m1);
    run(0, 0, 0, 9, 1, m1);
    run(1, 0, 0, 4, 1, m1);
    run(1, 1, 16'h0BAD, 5, 0, m1);

    // Abort during the third PLACE cycle
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("abort_map", map_a, 0);
    chk("abort_cnt", cnt_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    @(negedge clk);
    resetn = 1'b1;
    dn = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      dn += int'(done_a) + int'(busy_a);
    end
    chk("abort_quiet", dn, 0);
    chk("abort_map_held", map_a, 0);
    run(0, 0, 0, 20, 0, m1);

    for (int i = 0; i < 60; i++) begin
      seed_in = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      load(seed_in);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      if ($urandom_range(0, 1) == 1)
        run(1, 0, 0, $urandom_range(0, SR * SC - 1), 0, m1);
      else
        run(0, 0, 0, $urandom_range(0, 63), $urandom_range(0, 1) == 1, m1);
    end

`ifdef MINE_SAFE_ZONE_EN
    for (int i = 0; i < 1000; i++) begin
      safe = (i % 3 == 0) ? 0 : (i % 3 == 1) ? 15 : $urandom_range(0, 63);
      run(0, 1, 16'($urandom), safe, 0, m1);
      if (safe == 0) chk("safe0_clear", m1 & 64'h303, 0);
      if (safe == 15) begin
        chk("safe15_clear", m1 & 64'hC0C0C0, 0);
        if (m1[16]) hit16++;
      end
    end
    chk("bit16_eligible", hit16 > 0, 1);
`else
    safe = 0;
    chk("bit16_unused", hit16 + safe, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
